booth_ctrl: RTL and testbench

Control unit for the radix-2 Booth signed multiplier datapath: multiplicand register M, accumulator A, multiplier register Q with Q[-1], and the adder/subtractor.
- Sequences operand loading from the shared ibus, the WIDTH add/sub/shift iterations, and result unloading onto the shared obus (A first, then Q).
- All outputs are control strobes into the datapath plus a valid/ready handshake toward the host.

---
 rtl/booth_defs.sv | 16 +
 rtl/booth_cnt.sv | 28 ++
 rtl/booth_ctrl.sv | 155 +++++++++++++++
 tb/tb_booth_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_defs.sv
// rtl/booth_defs.sv - shared state encodings and default width for the Booth multiplier controller
package booth_defs;

    localparam int DEF_WIDTH = 8;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LOAD_M = 4'd1;
    localparam logic [3:0] LOAD_Q = 4'd2;
    localparam logic [3:0] CHECK  = 4'd3;
    localparam logic [3:0] ADD    = 4'd4;
    localparam logic [3:0] SUB    = 4'd5;
    localparam logic [3:0] SHIFT  = 4'd6;
    localparam logic [3:0] OUT_A  = 4'd7;
    localparam logic [3:0] OUT_Q  = 4'd8;

endpackage

// File: rtl/booth_cnt.sv
// rtl/booth_cnt.sv - Booth iteration counter with clear/increment and last-iteration flag
module booth_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    // clr wins over inc so a terminal SHIFT or abort always leaves the counter at zero
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - radix-2 Booth multiplier control unit; optional abort input under BOOTH_ABORT_EN
module booth_ctrl
    import booth_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
`ifdef BOOTH_ABORT_EN
    input  logic abort,
`endif
    input  logic in_vld,
    output logic in_rdy,
    input  logic q0,
    input  logic q_m1,
    input  logic out_rdy,
    output logic out_vld,
    output logic ld_m,
    output logic clr_a,
    output logic ld_q,
    output logic clr_lsb,
    output logic add_en,
    output logic sub,
    output logic sh_r,
    output logic obus_a,
    output logic obus_q,
    output logic busy,
    output logic done
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_last;
    logic       strobe_en;

`ifdef BOOTH_ABORT_EN
    assign strobe_en = !(abort && (state != IDLE));
`else
    assign strobe_en = 1'b1;
`endif

    booth_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD_M;
            LOAD_M: if (in_vld) state_nxt = LOAD_Q;
            LOAD_Q: begin
                if (in_vld) begin
                    state_nxt = CHECK;
                    cnt_clr   = 1'b1;
                end
            end
            CHECK: begin
                case ({q0, q_m1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD:    state_nxt = SHIFT;
            SUB:    state_nxt = SHIFT;
            SHIFT: begin
                if (cnt_last) begin
                    state_nxt = OUT_A;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = CHECK;
                    cnt_inc   = 1'b1;
                end
            end
            OUT_A:  if (out_rdy) state_nxt = OUT_Q;
            OUT_Q:  if (out_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort overrides every transition and leaves the counter clean for the next run
        if (!strobe_en) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b0;
        end
    end

    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        ld_m    = 1'b0;
        clr_a   = 1'b0;
        ld_q    = 1'b0;
        clr_lsb = 1'b0;
        add_en  = 1'b0;
        sub     = 1'b0;
        sh_r    = 1'b0;
        obus_a  = 1'b0;
        obus_q  = 1'b0;
        done    = 1'b0;
        if (strobe_en) begin
            case (state)
                LOAD_M: begin
                    in_rdy  = 1'b1;
                    ld_m    = in_vld;
                    clr_a   = in_vld;
                    clr_lsb = in_vld;
                end
                LOAD_Q: begin
                    in_rdy = 1'b1;
                    ld_q   = in_vld;
                end
                ADD:    add_en = 1'b1;
                SUB: begin
                    add_en = 1'b1;
                    sub    = 1'b1;
                end
                SHIFT:  sh_r = 1'b1;
                OUT_A: begin
                    out_vld = 1'b1;
                    obus_a  = 1'b1;
                end
                OUT_Q: begin
                    out_vld = 1'b1;
                    obus_q  = 1'b1;
                    done    = out_rdy;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_ctrl.sv
// tb/tb_booth_ctrl.sv - scoreboard bench for booth_ctrl driving a behavioural Booth datapath
module tb_booth_ctrl;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start = 1'b0;
    logic       in_vld = 1'b0;
    logic       out_rdy = 1'b0;
    logic       in_rdy, out_vld, ld_m, clr_a, ld_q, clr_lsb;
    logic       add_en, sub, sh_r, obus_a, obus_q, busy, done;
    logic       q0, q_m1;
    logic [7:0] ibus = 8'h00;
    logic [7:0] obus;
`ifdef BOOTH_ABORT_EN
    logic       abort = 1'b0;
`endif

    always #5 clk = ~clk;

    booth_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
`ifdef BOOTH_ABORT_EN
        .abort   (abort),
`endif
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .q0      (q0),
        .q_m1    (q_m1),
        .out_rdy (out_rdy),
        .out_vld (out_vld),
        .ld_m    (ld_m),
        .clr_a   (clr_a),
        .ld_q    (ld_q),
        .clr_lsb (clr_lsb),
        .add_en  (add_en),
        .sub     (sub),
        .sh_r    (sh_r),
        .obus_a  (obus_a),
        .obus_q  (obus_q),
        .busy    (busy),
        .done    (done)
    );

    // datapath: accumulator carries a guard bit so (-128)*(-128) fits
    logic [8:0] m_r, a_r;
    logic [7:0] q_r;
    logic       qm1_r;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_r <= '0; a_r <= '0; q_r <= '0; qm1_r <= 1'b0;
        end else begin
            if (ld_m)    m_r <= {ibus[7], ibus};
            if (clr_a)   a_r <= '0;
            if (clr_lsb) qm1_r <= 1'b0;
            if (ld_q) begin
                q_r   <= ibus;
                qm1_r <= 1'b0;
            end
            if (add_en)  a_r <= sub ? a_r - m_r : a_r + m_r;
            if (sh_r)    {a_r, q_r, qm1_r} <= {a_r[8], a_r, q_r};
        end
    end

    assign q0   = q_r[0];
    assign q_m1 = qm1_r;
    assign obus = obus_a ? a_r[7:0] : (obus_q ? q_r : 8'h00);

    typedef struct {
        logic [7:0] a;
        logic [7:0] q;
        int         ncomp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    int         comp_cnt = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_val = 8'h00;

    always @(negedge clk) begin
        if (!rst_b) begin
            comp_cnt = 0;
            hold_v   = 1'b0;
        end else begin
            check("strobe_legal",
                  int'(((ld_m | ld_q) & !in_vld) | (in_rdy & out_vld)
                       | (done & !(out_vld & out_rdy & obus_q))
                       | ($countones({ld_m, ld_q, add_en, sh_r, obus_a, obus_q}) > 1)), 0);
            if (in_rdy) comp_cnt = 0;
            else if (busy && !out_vld) comp_cnt++;
            if (out_vld && obus_a && !out_rdy) begin
                if (hold_v) check("obus_a_stable", obus, hold_val);
                hold_v   = 1'b1;
                hold_val = obus;
            end else begin
                hold_v = 1'b0;
            end
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else if (obus_a) begin
                    check("word_a", obus, sb[0].a);
                    check("done_at_a", done, 0);
                    if (sb[0].ncomp >= 0) check("compute_cycles", comp_cnt, sb[0].ncomp);
                end else begin
                    check("word_q", obus, sb[0].q);
                    check("done_at_q", done, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] m, input logic [7:0] q, input logic [7:0] ea,
                       input logic [7:0] eq, input int ncomp, input int bp_in,
                       input int bp_out, input bit pulse);
        int i;
        sb.push_back('{a: ea, q: eq, ncomp: ncomp});
        out_rdy = (bp_out == 0);
        start = 1'b1;
        tick();
        start  = 1'b0;
        in_vld = 1'b0;
        if (bp_in > 0) begin
            repeat (bp_in) tick();
            check("hold_load_m", in_rdy, 1);
        end
        ibus   = m;
        in_vld = 1'b1;
        tick();
        ibus = q;
        tick();
        in_vld = 1'b0;
        ibus   = 8'h00;
        if (pulse) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (i = 0; i < 100 && !out_vld; i++) tick();
        check("out_vld_timeout", out_vld, 1);
        if (bp_out > 0) begin
            repeat (bp_out) tick();
            check("hold_out_a", obus_a, 1);
            out_rdy = 1'b1;
        end
        for (i = 0; i < 10 && busy; i++) tick();
        check("idle_after_run", busy, 0);
        repeat (2) tick();
        check("stays_idle", busy, 0);
    endtask

    initial begin
        int n;
        #2;
        check("reset_outputs",
              {in_rdy, out_vld, ld_m, clr_a, ld_q, clr_lsb, add_en, sub, sh_r,
               obus_a, obus_q, busy, done}, 0);
        tick();
        rst_b = 1'b1;
        tick();

        run(8'h05, 8'hFD, 8'hFF, 8'hF1, 19, 0, 0, 1'b0);
        run(8'h80, 8'h80, 8'h40, 8'h00, 17, 0, 0, 1'b0);
        run(8'h12, 8'h00, 8'h00, 8'h00, 16, 0, 0, 1'b0);
        run(8'h7F, 8'h55, 8'h2A, 8'h2B, 24, 0, 0, 1'b0);
        run(8'h03, 8'h07, 8'h00, 8'h15, 18, 3, 4, 1'b1);

        // reset in the SHIFT of iteration 4
        start = 1'b1;
        tick();
        start  = 1'b0;
        ibus   = 8'h55;
        in_vld = 1'b1;
        tick();
        ibus = 8'h33;
        tick();
        in_vld = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            if (sh_r) n++;
        end
        check("reach_shift4", n, 5);
        #1 rst_b = 1'b0;
        #1;
        check("midop_reset_outputs",
              {in_rdy, out_vld, ld_m, clr_a, ld_q, clr_lsb, add_en, sub, sh_r,
               obus_a, obus_q, busy, done}, 0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick();
        run(8'hF9, 8'h09, 8'hFF, 8'hC1, -1, 0, 0, 1'b0);

`ifdef BOOTH_ABORT_EN
        start = 1'b1;
        tick();
        start  = 1'b0;
        ibus   = 8'h03;
        in_vld = 1'b1;
        tick();
        ibus = 8'h02;
        tick();
        in_vld = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n == 0; i++) begin
            @(negedge clk);
            if (add_en && !sub) n = 1;
        end
        check("reach_add", n, 1);
        #1 abort = 1'b1;
        #1;
        check("abort_strobes",
              {in_rdy, out_vld, ld_m, clr_a, ld_q, clr_lsb, add_en, sub, sh_r,
               obus_a, obus_q, done}, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_idle", busy, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_in_idle_ignored", busy, 1);
        for (int i = 0; i < 3; i++) tick();
        rst_b = 1'b0;
        #1 rst_b = 1'b1;
        tick();
        run(8'h03, 8'h07, 8'h00, 8'h15, 18, 0, 0, 1'b0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
